mul_operand_sequencer: RTL
==========================

# mul_operand_sequencer

- Front-end feeder and result collector for the repeated-addition multiplier (datapath + control path).
- Accepts operand pairs through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each pair onto the multiplier's shared 16-bit `data_in` bus, with the `start` pulse aligned to the load cycles.
- Waits for `done`, then returns the product with a watchdog error flag on a valid/ready output.

## Interface

**Parameters**
- `W`, default 16: operand width; also the width of the shared data bus.
- `PW`, default 16: product width as delivered by the multiplier.
- `DEPTH`, default 4: operand FIFO depth (power of two, ≥2).
- `TIMEOUT`, default 1023: maximum cycles to wait for `done` before aborting.

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk` — input, 1 — rising-edge clock.
  - `rst` — input, 1 — synchronous active-high reset.
- Operand input handshake:
  - `in_valid` — input, 1 — operand pair offered.
  - `in_a` — input, W — multiplicand, loaded via `lda`.
  - `in_b` — input, W — multiplier/count, loaded via `ldb`.
  - `in_ready` — output, 1 — FIFO not full.
- Multiplier-facing signals:
  - `mul_start` — output, 1 — start to the multiplier control path.
  - `mul_data` — output, W — drives the multiplier `data_in`.
  - `mul_done` — input, 1 — done from the control path.
  - `mul_product` — input, PW — product register value.
- Result output handshake:
  - `out_valid` — output, 1 — result held.
  - `out_product` — output, PW — captured product.
  - `out_err` — output, 1 — watchdog expired; product forced to 0.
  - `out_ready` — input, 1 — consumer accepts the result.

## Operation

**FIFO**
- Push when `in_valid && in_ready`.
- Pop occurs on entry to `ST_START`.
- Push and pop in the same cycle while full: the push is refused, because `in_ready` is computed from the registered full flag.

**Sequencer FSM**
- `ST_IDLE`: if the FIFO is not empty and the result slot is free (`!out_valid`), pop the pair into the A/B registers and go to `ST_START`.
- `ST_START`: `mul_start=1`, `mul_data=A`. Next state is `ST_LDA`.
- `ST_LDA`: `mul_start=1`, `mul_data=A`. Next state is `ST_LDB`.
- `ST_LDB`: `mul_start=0`, `mul_data=B`. Next state is `ST_WAIT`; clear the watchdog counter.
- `ST_WAIT`: hold `mul_data=B`.
  - If `mul_done=1`: capture `mul_product` into `out_product`, set `out_valid=1` and `out_err=0`, go to `ST_IDLE`.
  - Otherwise, when the counter equals TIMEOUT: set `out_product=0`, `out_err=1`, `out_valid=1`, go to `ST_IDLE`.
- Output slot: `out_valid` clears on `out_valid && out_ready`. The next pair is not popped until the slot is empty, so there is at most one multiplication in flight.
- `mul_done` outside `ST_WAIT` is ignored.
- Widths:
  - The watchdog counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.
  - A and B are stored unmodified.

## Timing

- Reset values:
  - `in_ready=1`, `mul_start=0`, `mul_data=0`, `out_valid=0`, `out_product=0`, `out_err=0`.
  - FSM in `ST_IDLE`, FIFO empty, counter 0.
- Latency:
  - Push to `ST_START` is 2 cycles (FIFO write, then pop) when idle.
  - `ST_START` to `ST_WAIT` is 3 cycles.
  - `mul_done` sampled high produces `out_valid` on the next edge.
- Reset asserted mid-operation:
  - Abandons any pair in flight and flushes the FIFO.
  - Deasserts `mul_start` the cycle after the reset edge.
  - Discards a held result.
- `out_valid`, `out_product` and `out_err` are stable until accepted.

## Configuration

- Macro: `MUL_SEQ_ZERO_BYPASS_EN`.
- Defined:
  - In `ST_IDLE`, if the popped A==0 or B==0, skip the multiplier entirely (no `mul_start`).
  - Set `out_product=0`, `out_err=0`, `out_valid=1` one cycle after the pop.
- Undefined: every pair goes through the multiplier, including zero operands.

## Structure

- Package `mul_seq_pkg`:
  - State enum (`ST_IDLE`, `ST_START`, `ST_LDA`, `ST_LDB`, `ST_WAIT`).
  - Default width constants.
  - Counter-width function.
- Sub-module `mul_seq_fifo`:
  - Synchronous FIFO, width 2*W, parameterised DEPTH.
  - Registered full/empty flags; pointers one bit wider than the address.

## Test plan

- **Basic pair:** push A=5, B=4 against the real multiplier → `mul_data` shows 5 for 2 cycles (with `mul_start`), then 4; `out_product=20`, `out_err=0`.
- **Back-pressure:** push 5 pairs with `DEPTH=4` while `out_ready=0` → `in_ready` drops after 4 buffered; first result holds; each later pair issues only after its predecessor's result is accepted; order is preserved.
- **Watchdog:** stub that never raises `mul_done`, TIMEOUT=15 → `out_err=1` and `out_product=0` after 16 `ST_WAIT` cycles, then the next pair is serviced normally.
- **Zero operand:** push A=7, B=0.
  - With `MUL_SEQ_ZERO_BYPASS_EN`: no `mul_start`, product 0 at pop+1.
  - Without it: normal sequence, product 0.
- **Reset mid-operation:** assert `rst` during `ST_LDA` with 2 pairs queued → next cycle all outputs are at reset values and FIFO is empty; a fresh pair 3×3 returns 9.
- **Stray done:** pulse `mul_done` in `ST_IDLE` → no `out_valid`.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the multiplier operand sequencer:
// FSM state encoding, default widths and the watchdog counter width helper.
package mul_seq_pkg;

  localparam int unsigned DEF_W       = 16;
  localparam int unsigned DEF_PW      = 16;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LDA,
    ST_LDB,
    ST_WAIT
  } state_t;

  // Bits needed to count 0..timeout inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mul_seq_fifo.sv
// Synchronous operand FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mul_seq_fifo
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DEF_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_next;
  logic [AW:0]      rd_ptr_next;
  logic             do_push;
  logic             do_pop;

  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign wr_ptr_next = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_pop};
  assign rdata       = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the empty flag guards every read,
  // and leaving the array reset-free lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      empty  <= (wr_ptr_next == rd_ptr_next);
    end
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds buffered operand pairs to the repeated-addition multiplier and returns
// each product (or a watchdog error) on a held valid/ready output.
// Optional macro MUL_SEQ_ZERO_BYPASS_EN: pairs with a zero operand skip the multiplier.
module mul_operand_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned PW      = DEF_PW,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          in_ready,
  output logic          mul_start,
  output logic [W-1:0]  mul_data,
  input  logic          mul_done,
  input  logic [PW-1:0] mul_product,
  output logic          out_valid,
  output logic [PW-1:0] out_product,
  output logic          out_err,
  input  logic          out_ready
);

  localparam int unsigned     CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT);

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [CW-1:0]   cnt_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic [2*W-1:0]  fifo_rdata;
  logic [W-1:0]    pop_a;
  logic [W-1:0]    pop_b;
  logic            pop;
  logic            res_set;
  logic            res_err;
  logic [PW-1:0]   res_product;

  assign in_ready = !fifo_full;
  assign pop_a    = fifo_rdata[2*W-1:W];
  assign pop_b    = fifo_rdata[W-1:0];

  mul_seq_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mul_start   = 1'b0;
    mul_data    = '0;
    res_set     = 1'b0;
    res_err     = 1'b0;
    res_product = '0;
    unique case (state_q)
      ST_IDLE: begin
        // One multiplication in flight: wait for the result slot to drain.
        if (!fifo_empty && !out_valid) begin
          pop = 1'b1;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
          if (pop_a == '0 || pop_b == '0) res_set = 1'b1;
          else                            state_d = ST_START;
`else
          state_d = ST_START;
`endif
        end
      end
      ST_START: begin
        mul_start = 1'b1;
        mul_data  = a_q;
        state_d   = ST_LDA;
      end
      ST_LDA: begin
        mul_start = 1'b1;
        mul_data  = a_q;
        state_d   = ST_LDB;
      end
      ST_LDB: begin
        mul_data = b_q;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        mul_data = b_q;
        if (mul_done) begin
          res_set     = 1'b1;
          res_product = mul_product;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          res_set = 1'b1;
          res_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        a_q <= pop_a;
        b_q <= pop_b;
      end
      // Watchdog saturates at TIMEOUT instead of wrapping.
      if (state_q == ST_LDB)
        cnt_q <= '0;
      else if (state_q == ST_WAIT && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CW'(1);
      if (res_set) begin
        out_valid   <= 1'b1;
        out_product <= res_product;
        out_err     <= res_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
